// File: rtl/alu_pkg.sv
// Shared op encodings, FSM state type and small op-decode helpers for the
// bit-serial ALU sequencer.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic uses_binvert(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic has_overflow(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequencer FSM and LSB-first bit counter for the bit-serial ALU.
//
// state | meaning
// IDLE  | waiting for start, slice inputs held at 0
// CMP   | SLT pre-pass: a-b run through the slice to derive the less bit
// RUN   | main pass, one result bit per cycle
// DONE  | one-cycle completion pulse, start ignored
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          is_slt_i,
  output state_e        state_o,
  output logic [CW-1:0] bit_o,
  output logic          last_o,
  output logic          accept_o
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last     = (cnt_q == CW'(WIDTH - 1));
  assign last_o   = last;
  assign state_o  = state_q;
  assign bit_o    = cnt_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          accept_o = 1'b1;
          cnt_d    = '0;
          state_d  = is_slt_i ? CMP : RUN;
        end
      end
      CMP: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) state_d = RUN;
      end
      RUN: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU sequencer driving one external 1-bit ALU slice, LSB first.
// Define ALU_SEQ_FLAGS_EN to build the zero/overflow flag registers.
module alu_bitserial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_binvert,
  output logic             alu_cin,
  output logic             alu_less,
  output logic [2:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_cout
);

  localparam int CW = $clog2(WIDTH);

  state_e           state;
  logic [CW-1:0]    bit_idx;
  logic             last, accept, active, first;

  logic [WIDTH-1:0] a_q, b_q, res_sh_q, res_sh_d, result_q;
  logic [2:0]       op_q;
  logic             cout_q, less_q, carry_q;

  alu_seq_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .is_slt_i (op == OP_SLT),
    .state_o  (state),
    .bit_o    (bit_idx),
    .last_o   (last),
    .accept_o (accept)
  );

  assign active = (state == CMP) || (state == RUN);
  assign first  = (bit_idx == '0);
  assign busy   = active;
  assign done   = (state == DONE);

  always_comb begin
    alu_a       = 1'b0;
    alu_b       = 1'b0;
    alu_binvert = 1'b0;
    alu_cin     = 1'b0;
    alu_less    = 1'b0;
    alu_op      = 3'b000;
    if (active) begin
      alu_a       = a_q[bit_idx];
      alu_b       = b_q[bit_idx];
      alu_binvert = uses_binvert(op_q);
      alu_cin     = first ? alu_binvert : cout_q;
      alu_op      = (state == CMP) ? OP_SUB : op_q;
      alu_less    = (state == RUN) && (op_q == OP_SLT) && first && less_q;
    end
  end

  always_comb begin
    res_sh_d          = res_sh_q;
    res_sh_d[bit_idx] = alu_result;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cout_q   <= 1'b0;
      less_q   <= 1'b0;
      res_sh_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
      if (active) cout_q <= alu_cout;
      // signed less-than: sign of a-b corrected by the MSB overflow
      if (state == CMP && last) less_q <= alu_result ^ (alu_cin ^ alu_cout);
      if (state == RUN) begin
        res_sh_q <= res_sh_d;
        if (last) begin
          result_q <= res_sh_d;
          carry_q  <= alu_cout;
        end
      end
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q, ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == RUN && last) begin
      zero_q <= (res_sh_d == '0);
      ovf_q  <= has_overflow(op_q) && (alu_cin ^ alu_cout);
    end
  end

  assign zero     = zero_q;
  assign overflow = ovf_q;
`else
  assign zero     = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule
